// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU operations, operand/destination
// selects and the multiply/divide sequencer states.
package exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOR  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_MULT = 4'd10,
        OP_DIV  = 4'd11,
        OP_MFHI = 4'd12,
        OP_MFLO = 4'd13
    } alu_op_t;

    typedef enum logic [1:0] {
        DST_RT   = 2'd0,
        DST_RD   = 2'd1,
        DST_RA   = 2'd2,
        DST_ZERO = 2'd3
    } reg_dst_t;

    typedef enum logic [1:0] {
        SRCB_REG = 2'd0,
        SRCB_IMM = 2'd1,
        SRCB_8   = 2'd2,
        SRCB_16  = 2'd3
    } src_b_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX -> EX/MEM bundle of the execute stage; upstream drives master, the
// stage itself sits on the slave side.
interface execute_stage_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int IDX_W   = 26
);
    logic               In_Valid;
    logic               Flush;
    logic [3:0]         ALUOp;
    logic               ALUSrc0;
    logic [1:0]         ALUSrc1;
    logic [1:0]         RegDst;
    logic [SHAMT_W-1:0] Shamt;
    logic [4:0]         Rt;
    logic [4:0]         Rd;
    logic [DATA_W-1:0]  Reg_Data1;
    logic [DATA_W-1:0]  Reg_Data2;
    logic [DATA_W-1:0]  Imm;
    logic [DATA_W-1:0]  PCPlusFour;
    logic [IDX_W-1:0]   Instr_Index;
    logic               Stall;
    logic               Out_Valid;
    logic [DATA_W-1:0]  ALUResult;
    logic               Zero;
    logic [4:0]         rDestSelected;
    logic [DATA_W-1:0]  PC_Plus_Branch;
    logic [DATA_W-1:0]  Jump_Target;

    modport master (
        output In_Valid, Flush, ALUOp, ALUSrc0, ALUSrc1, RegDst, Shamt, Rt, Rd,
               Reg_Data1, Reg_Data2, Imm, PCPlusFour, Instr_Index,
        input  Stall, Out_Valid, ALUResult, Zero, rDestSelected,
               PC_Plus_Branch, Jump_Target
    );

    modport slave (
        input  In_Valid, Flush, ALUOp, ALUSrc0, ALUSrc1, RegDst, Shamt, Rt, Rd,
               Reg_Data1, Reg_Data2, Imm, PCPlusFour, Instr_Index,
        output Stall, Out_Valid, ALUResult, Zero, rDestSelected,
               PC_Plus_Branch, Jump_Target
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative unsigned shift-add multiplier / restoring divider owning HI and LO.
// One bit per BUSY cycle, DATA_W cycles per operation, one DONE cycle to commit.
module mul_div_unit
    import exec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_div,
    input  logic              flush,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] result_lo
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    md_state_t         state, state_next;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] work_hi, work_lo, operand_b;
    logic              is_div_q;

    logic [DATA_W:0]   mul_sum, div_shifted, div_diff;
    logic [DATA_W-1:0] step_hi, step_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MD_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (start) state_next = MD_BUSY;
            MD_BUSY: begin
                if (flush)                              state_next = MD_IDLE;
                else if (count == CNT_W'(DATA_W - 1))   state_next = MD_DONE;
            end
            MD_DONE: state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    // Divider keeps the partial remainder in work_hi and shifts the quotient
    // into work_lo; a zero divisor naturally yields all-ones / dividend.
    always_comb begin
        mul_sum     = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand_b} : '0);
        div_shifted = {work_hi, work_lo[DATA_W-1]};
        div_diff    = div_shifted - {1'b0, operand_b};
        if (is_div_q) begin
            if (!div_diff[DATA_W]) begin
                step_hi = div_diff[DATA_W-1:0];
                step_lo = {work_lo[DATA_W-2:0], 1'b1};
            end else begin
                step_hi = div_shifted[DATA_W-1:0];
                step_lo = {work_lo[DATA_W-2:0], 1'b0};
            end
        end else begin
            {step_hi, step_lo} = {mul_sum, work_lo[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            work_hi   <= '0;
            work_lo   <= '0;
            operand_b <= '0;
            is_div_q  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        count     <= '0;
                        work_hi   <= '0;
                        work_lo   <= op_a;
                        operand_b <= op_b;
                        is_div_q  <= is_div;
                    end
                end
                MD_BUSY: begin
                    count   <= count + CNT_W'(1);
                    work_hi <= step_hi;
                    work_lo <= step_lo;
                end
                MD_DONE: begin
                    if (!flush) begin
                        hi <= work_hi;
                        lo <= work_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == MD_BUSY);
    assign done      = (state == MD_DONE);
    assign result_lo = work_lo;

endmodule

// File: rtl/execute_stage.sv
// Pipeline execute stage: operand muxes, single-cycle ALU, branch/jump target
// adders and registered EX/MEM outputs, with an iterative MULT/DIV unit.
module execute_stage
    import exec_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int IDX_W   = 26
) (
    input logic            Clk,
    input logic            Rst_n,
    execute_stage_if.slave ex
);
    localparam logic [DATA_W-1:0] JUMP_MASK = DATA_W'({IDX_W{1'b1}}) << 2;

    alu_op_t           op;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [SHAMT_W-1:0] shamt;
    logic [4:0]        dest;
    logic [DATA_W-1:0] pc_branch, jump_target;
    logic              accept, md_start, md_busy, md_done;
    logic [DATA_W-1:0] md_hi, md_lo, md_result_lo;

    assign op = alu_op_t'(ex.ALUOp);

    always_comb begin
        alu_a = ex.ALUSrc0 ? DATA_W'(ex.Shamt) : ex.Reg_Data1;
        case (src_b_t'(ex.ALUSrc1))
            SRCB_REG: alu_b = ex.Reg_Data2;
            SRCB_IMM: alu_b = ex.Imm;
            SRCB_8:   alu_b = DATA_W'(8);
            SRCB_16:  alu_b = DATA_W'(16);
            default:  alu_b = ex.Reg_Data2;
        endcase
        shamt = alu_a[SHAMT_W-1:0];
    end

    always_comb begin
        alu_result = '0;
        case (op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_NOR:  alu_result = ~(alu_a | alu_b);
            OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            OP_SLL:  alu_result = alu_b << shamt;
            OP_SRL:  alu_result = alu_b >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(alu_b) >>> shamt);
            OP_MFHI: alu_result = md_hi;
            OP_MFLO: alu_result = md_lo;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        case (reg_dst_t'(ex.RegDst))
            DST_RT:   dest = ex.Rt;
            DST_RD:   dest = ex.Rd;
            DST_RA:   dest = 5'd31;
            DST_ZERO: dest = 5'd0;
            default:  dest = 5'd0;
        endcase
        pc_branch   = ex.PCPlusFour + (ex.Imm << 2);
        jump_target = (ex.PCPlusFour & ~JUMP_MASK) | (DATA_W'(ex.Instr_Index) << 2);
    end

    // The DONE cycle belongs to the MULT/DIV still held upstream, so nothing new
    // is taken in until the sequencer is back in IDLE.
    assign accept   = ex.In_Valid && !md_busy && !md_done && !ex.Flush;
    assign md_start = accept && ((op == OP_MULT) || (op == OP_DIV));
    assign ex.Stall = md_busy;

    mul_div_unit #(.DATA_W(DATA_W)) u_mul_div (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .start     (md_start),
        .is_div    (op == OP_DIV),
        .flush     (ex.Flush),
        .op_a      (alu_a),
        .op_b      (alu_b),
        .busy      (md_busy),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo),
        .result_lo (md_result_lo)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ex.Out_Valid      <= 1'b0;
            ex.ALUResult      <= '0;
            ex.Zero           <= 1'b0;
            ex.rDestSelected  <= '0;
            ex.PC_Plus_Branch <= '0;
            ex.Jump_Target    <= '0;
        end else begin
            ex.Out_Valid <= 1'b0;
            if (md_done && !ex.Flush) begin
                ex.Out_Valid     <= 1'b1;
                ex.ALUResult     <= md_result_lo;
                ex.Zero          <= (md_result_lo == '0);
                ex.rDestSelected <= 5'd0;
            end else if (accept && !md_start) begin
                ex.Out_Valid      <= 1'b1;
                ex.ALUResult      <= alu_result;
                ex.Zero           <= (alu_result == '0);
                ex.rDestSelected  <= dest;
                ex.PC_Plus_Branch <= pc_branch;
                ex.Jump_Target    <= jump_target;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage with hand-computed expectations.
module tb_execute_stage;
    import exec_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   vectorCount = 0;
    int   missCount   = 0;
    int   stallCycles;
    logic sawValid;

    execute_stage_if #(.DATA_W(32), .SHAMT_W(5), .IDX_W(26)) ex ();

    execute_stage #(.DATA_W(32), .SHAMT_W(5), .IDX_W(26)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .ex    (ex)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clearInputs();
        ex.In_Valid    = 1'b0;
        ex.Flush       = 1'b0;
        ex.ALUOp       = 4'd0;
        ex.ALUSrc0     = 1'b0;
        ex.ALUSrc1     = 2'd0;
        ex.RegDst      = 2'd0;
        ex.Shamt       = 5'd0;
        ex.Rt          = 5'd0;
        ex.Rd          = 5'd0;
        ex.Reg_Data1   = 32'd0;
        ex.Reg_Data2   = 32'd0;
        ex.Imm         = 32'd0;
        ex.PCPlusFour  = 32'd0;
        ex.Instr_Index = 26'd0;
    endtask

    // Other fields are set by the caller beforehand; cleared again afterwards.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2);
        ex.ALUOp     = op;
        ex.Reg_Data1 = d1;
        ex.Reg_Data2 = d2;
        ex.In_Valid  = 1'b1;
        tick();
        clearInputs();
    endtask

    task automatic waitStall(output int n);
        n = 0;
        while (ex.Stall && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic watchNoValid(input int cycles, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (ex.Out_Valid) seen = 1'b1;
        end
    endtask

    initial begin
        clearInputs();
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_valid", ex.Out_Valid, 0);
        checkOutput("rst_stall", ex.Stall, 0);
        checkOutput("rst_result", ex.ALUResult, 0);
        checkOutput("rst_zero", ex.Zero, 0);
        checkOutput("rst_dest", ex.rDestSelected, 0);
        checkOutput("rst_pcb", ex.PC_Plus_Branch, 0);
        checkOutput("rst_jt", ex.Jump_Target, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        ex.Rt = 5'd3;
        applyStimulus(OP_ADD, 32'd5, 32'd7);
        checkOutput("add_valid", ex.Out_Valid, 1);
        checkOutput("add_result", ex.ALUResult, 12);
        checkOutput("add_zero", ex.Zero, 0);
        checkOutput("add_dest", ex.rDestSelected, 3);

        ex.RegDst = 2'd2;
        applyStimulus(OP_SUB, 32'd9, 32'd9);
        checkOutput("sub_result", ex.ALUResult, 0);
        checkOutput("sub_zero", ex.Zero, 1);
        checkOutput("sub_dest", ex.rDestSelected, 31);

        ex.ALUSrc1 = 2'd1; ex.RegDst = 2'd1; ex.Rd = 5'd9;
        ex.PCPlusFour = 32'h100; ex.Imm = 32'hFFFF_FFFF; ex.Instr_Index = 26'h40;
        applyStimulus(OP_ADD, 32'd0, 32'd0);
        checkOutput("br_pcb", ex.PC_Plus_Branch, 32'hFC);
        checkOutput("br_jt", ex.Jump_Target, 32'h100);
        checkOutput("br_imm_result", ex.ALUResult, 32'hFFFF_FFFF);
        checkOutput("br_dest", ex.rDestSelected, 9);

        tick();
        checkOutput("idle_valid", ex.Out_Valid, 0);

        applyStimulus(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        checkOutput("slt_neg", ex.ALUResult, 1);
        applyStimulus(OP_SLT, 32'd1, 32'hFFFF_FFFF);
        checkOutput("slt_pos", ex.ALUResult, 0);

        ex.ALUSrc0 = 1'b1; ex.Shamt = 5'd4;
        applyStimulus(OP_SRA, 32'd0, 32'h8000_0000);
        checkOutput("sra", ex.ALUResult, 32'hF800_0000);
        ex.ALUSrc0 = 1'b1; ex.Shamt = 5'd4;
        applyStimulus(OP_SRL, 32'd0, 32'h8000_0000);
        checkOutput("srl", ex.ALUResult, 32'h0800_0000);
        applyStimulus(OP_SLL, 32'd4, 32'd1);
        checkOutput("sll_reg_amount", ex.ALUResult, 32'h10);

        applyStimulus(OP_NOR, 32'h0F0F_0F0F, 32'hF0F0_F000);
        checkOutput("nor", ex.ALUResult, 32'h0000_00F0);
        applyStimulus(OP_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0);
        checkOutput("xor", ex.ALUResult, 32'hF0F0_F0F0);
        applyStimulus(OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
        checkOutput("and", ex.ALUResult, 32'h0F00_0F00);
        applyStimulus(OP_OR, 32'hFF00_0000, 32'h0000_00FF);
        checkOutput("or", ex.ALUResult, 32'hFF00_00FF);
        applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'd2);
        checkOutput("add_wrap", ex.ALUResult, 1);

        ex.ALUSrc1 = 2'd2; ex.RegDst = 2'd3; ex.Rt = 5'd5; ex.Rd = 5'd7;
        applyStimulus(OP_ADD, 32'd100, 32'd0);
        checkOutput("src_const8", ex.ALUResult, 108);
        checkOutput("dst_zero", ex.rDestSelected, 0);
        ex.ALUSrc1 = 2'd3;
        applyStimulus(OP_ADD, 32'd100, 32'd0);
        checkOutput("src_const16", ex.ALUResult, 116);

        applyStimulus(4'hF, 32'd3, 32'd4);
        checkOutput("undef_result", ex.ALUResult, 0);
        checkOutput("undef_zero", ex.Zero, 1);

        ex.Flush = 1'b1;
        applyStimulus(OP_ADD, 32'd1, 32'd1);
        checkOutput("flush_blocks", ex.Out_Valid, 0);

        applyStimulus(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        checkOutput("mult_stall_on", ex.Stall, 1);
        waitStall(stallCycles);
        checkOutput("mult_stall_len", stallCycles, 32);
        checkOutput("mult_done_novalid", ex.Out_Valid, 0);
        tick();
        checkOutput("mult_valid", ex.Out_Valid, 1);
        checkOutput("mult_lo", ex.ALUResult, 32'hFFFF_FFFE);
        checkOutput("mult_dest", ex.rDestSelected, 0);
        applyStimulus(OP_MFHI, 32'd0, 32'd0);
        checkOutput("mfhi_mult", ex.ALUResult, 1);
        applyStimulus(OP_MFLO, 32'd0, 32'd0);
        checkOutput("mflo_mult", ex.ALUResult, 32'hFFFF_FFFE);

        applyStimulus(OP_DIV, 32'd7, 32'd0);
        waitStall(stallCycles);
        checkOutput("div0_stall_len", stallCycles, 32);
        tick();
        checkOutput("div0_lo", ex.ALUResult, 32'hFFFF_FFFF);
        applyStimulus(OP_MFHI, 32'd0, 32'd0);
        checkOutput("div0_hi", ex.ALUResult, 7);

        applyStimulus(OP_DIV, 32'd17, 32'd5);
        waitStall(stallCycles);
        checkOutput("div_stall_len", stallCycles, 32);
        tick();
        checkOutput("div_lo", ex.ALUResult, 3);
        applyStimulus(OP_MFHI, 32'd0, 32'd0);
        checkOutput("div_hi", ex.ALUResult, 2);

        applyStimulus(OP_MULT, 32'd3, 32'd3);
        for (int i = 0; i < 9; i++) tick();
        checkOutput("flushbusy_stall", ex.Stall, 1);
        ex.Flush = 1'b1;
        tick();
        ex.Flush = 1'b0;
        checkOutput("flushbusy_idle", ex.Stall, 0);
        watchNoValid(40, sawValid);
        checkOutput("flushbusy_novalid", sawValid, 0);
        applyStimulus(OP_MFHI, 32'd0, 32'd0);
        checkOutput("flushbusy_hi", ex.ALUResult, 2);
        applyStimulus(OP_MFLO, 32'd0, 32'd0);
        checkOutput("flushbusy_lo", ex.ALUResult, 3);

        applyStimulus(OP_DIV, 32'd100, 32'd9);
        waitStall(stallCycles);
        checkOutput("flushdone_stall_len", stallCycles, 32);
        ex.Flush = 1'b1;
        tick();
        ex.Flush = 1'b0;
        checkOutput("flushdone_novalid", ex.Out_Valid, 0);
        applyStimulus(OP_MFLO, 32'd0, 32'd0);
        checkOutput("flushdone_lo", ex.ALUResult, 3);
        applyStimulus(OP_MFHI, 32'd0, 32'd0);
        checkOutput("flushdone_hi", ex.ALUResult, 2);

        ex.ALUSrc1 = 2'd1; ex.Imm = 32'd1; ex.PCPlusFour = 32'h200;
        ex.Instr_Index = 26'd3; ex.Rt = 5'd4;
        applyStimulus(OP_ADD, 32'd5, 32'd0);
        checkOutput("pre_rst_result", ex.ALUResult, 6);
        checkOutput("pre_rst_pcb", ex.PC_Plus_Branch, 32'h204);
        checkOutput("pre_rst_jt", ex.Jump_Target, 32'hC);
        applyStimulus(OP_DIV, 32'd50, 32'd3);
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_stall", ex.Stall, 0);
        checkOutput("midrst_valid", ex.Out_Valid, 0);
        checkOutput("midrst_result", ex.ALUResult, 0);
        checkOutput("midrst_dest", ex.rDestSelected, 0);
        checkOutput("midrst_pcb", ex.PC_Plus_Branch, 0);
        checkOutput("midrst_jt", ex.Jump_Target, 0);
        tick();
        rst_n = 1'b1;
        watchNoValid(40, sawValid);
        checkOutput("midrst_novalid", sawValid, 0);
        applyStimulus(OP_MFLO, 32'd0, 32'd0);
        checkOutput("midrst_lo", ex.ALUResult, 0);
        applyStimulus(OP_MFHI, 32'd0, 32'd0);
        checkOutput("midrst_hi", ex.ALUResult, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
